// File: rtl/sp_ram_ctrl_pkg.sv
// rtl/sp_ram_ctrl_pkg.sv - shared state encoding and timing constants for sp_ram_ctrl
package sp_ram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    RSP   = 3'd4,
    INIT  = 3'd5
  } state_t;

  // Edges from request accept to rsp_valid visible, accept edge included.
  localparam int READ_LATENCY = 3;

endpackage

// File: rtl/sp_ram.sv
// rtl/sp_ram.sv - single-port RAM with synchronous write and registered read data
module sp_ram #(
  parameter int DATA = 4,
  parameter int ADDR = 2
) (
  input  logic            clk,
  input  logic            we,
  input  logic            re,
  input  logic [ADDR-1:0] addr,
  input  logic [DATA-1:0] data_in,
  output logic [DATA-1:0] data_out
);

  logic [DATA-1:0] mem [2**ADDR];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data_in;
    if (re) data_out <= mem[addr];
  end

endmodule

// File: rtl/sp_ram_ctrl.sv
// rtl/sp_ram_ctrl.sv - request/response front-end for sp_ram; RAM_INIT_EN adds a zero-fill pass after reset
module sp_ram_ctrl
  import sp_ram_ctrl_pkg::*;
#(
  parameter int DATA = 4,
  parameter int ADDR = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [ADDR-1:0] req_addr,
  input  logic [DATA-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DATA-1:0] rsp_rdata,
  output logic            busy,
  output logic            ram_we,
  output logic            ram_re,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_wdata,
  input  logic [DATA-1:0] ram_rdata
);

`ifdef RAM_INIT_EN
  localparam state_t RESET_STATE = INIT;
  logic [ADDR-1:0] init_cnt;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t          state, state_nx;
  logic            we_q, we_d, re_q, re_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [DATA-1:0] wdata_q, wdata_d;
  logic            rv_q, rv_d;
  logic [DATA-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RESET_STATE;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nx;
      we_q    <= we_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef RAM_INIT_EN
  always_ff @(posedge clk) begin
    if (rst)                init_cnt <= '0;
    else if (state == INIT) init_cnt <= init_cnt + 1'b1;
  end
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = req_write ? WR : RD;
      WR:      state_nx = IDLE;
      RD:      state_nx = RWAIT;
      RWAIT:   state_nx = RSP;
      RSP:     if (rsp_ready) state_nx = IDLE;
`ifdef RAM_INIT_EN
      INIT:    if (init_cnt == '1) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; we/re default low so each is a one-cycle pulse.
  always_comb begin
    we_d    = 1'b0;
    re_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rv_d    = rv_q;
    rdata_d = rdata_q;
    unique case (state)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        we_d    = req_write;
        re_d    = !req_write;
      end
      RWAIT: begin
        rv_d    = 1'b1;
        rdata_d = ram_rdata;
      end
      RSP: if (rsp_ready) rv_d = 1'b0;
      default: ;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign ram_re    = re_q;
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;

`ifdef RAM_INIT_EN
  // The zero-fill pass overrides the write port while the counter sweeps the array.
  assign ram_we    = we_q | (state == INIT);
  assign ram_addr  = (state == INIT) ? init_cnt : addr_q;
  assign ram_wdata = (state == INIT) ? '0 : wdata_q;
`else
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
`endif

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// tb/tb_sp_ram_ctrl.sv - self-checking bench for sp_ram_ctrl driving a real sp_ram
`timescale 1ns/1ps
module tb_sp_ram_ctrl;
  import sp_ram_ctrl_pkg::*;

  localparam int DATA = 4;
  localparam int ADDR = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [ADDR-1:0] req_addr = '0;
  logic [DATA-1:0] req_wdata = '0;
  logic            rsp_valid, rsp_ready = 1'b0;
  logic [DATA-1:0] rsp_rdata;
  logic            busy, ram_we, ram_re;
  logic [ADDR-1:0] ram_addr;
  logic [DATA-1:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sp_ram_ctrl #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .ram_we(ram_we), .ram_re(ram_re),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  sp_ram #(.DATA(DATA), .ADDR(ADDR)) ram (
    .clk(clk), .we(ram_we), .re(ram_re), .addr(ram_addr),
    .data_in(ram_wdata), .data_out(ram_rdata)
  );

  assert property (@(posedge clk) !(ram_we && ram_re))
    else begin
      errors++;
      $display("FAIL we_re_overlap: ram_we=%b ram_re=%b required not both 1", ram_we, ram_re);
    end

  typedef struct {
    bit              wr;
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] data;
    int              hold;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !req_ready; i++) tick();
    check("wait_ready", int'(req_ready), 1);
  endtask

  task automatic do_write(input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_addr = ADDR'($urandom); req_wdata = DATA'($urandom);
    check("wr_we_pulse", int'(ram_we), 1);
    check("wr_addr", int'(ram_addr), int'(a));
    check("wr_data", int'(ram_wdata), int'(d));
    check("wr_no_re", int'(ram_re), 0);
    check("wr_ready_low", int'(req_ready), 0);
    tick();
    check("wr_we_clear", int'(ram_we), 0);
    check("wr_ready_back", int'(req_ready), 1);
  endtask

  task automatic do_read(input logic [ADDR-1:0] a, input int hold, input logic [DATA-1:0] exp);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = DATA'($urandom);
    tick();
    req_valid = 1'b0; req_addr = ADDR'($urandom);
    check("rd_re_pulse", int'(ram_re), 1);
    check("rd_addr", int'(ram_addr), int'(a));
    check("rd_no_we", int'(ram_we), 0);
    for (int e = 2; e < READ_LATENCY; e++) begin
      tick();
      check("rd_re_clear", int'(ram_re), 0);
      check("rd_early_valid", int'(rsp_valid), 0);
    end
    tick();
    check("rd_valid", int'(rsp_valid), 1);
    check("rd_data", int'(rsp_rdata), int'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", int'(rsp_valid), 1);
      check("hold_data", int'(rsp_rdata), int'(exp));
      check("hold_ready", int'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_done_valid", int'(rsp_valid), 0);
    check("rsp_done_ready", int'(req_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DATA-1:0] model [2**ADDR];
    bit              exp_ready, n_ready, wr_wait, rd_pend;
    logic [DATA-1:0] exp_data;
    int              done, cyc, acc, last;

    vecs[0] = '{1'b1, 2'd2, 4'hA, 0};
    vecs[1] = '{1'b0, 2'd2, 4'hA, 0};
    vecs[2] = '{1'b1, 2'd1, 4'h5, 0};
    vecs[3] = '{1'b0, 2'd1, 4'h5, 5};
    vecs[4] = '{1'b1, 2'd2, 4'hF, 0};
    vecs[5] = '{1'b0, 2'd2, 4'hF, 1};
    vecs[6] = '{1'b0, 2'd1, 4'h5, 0};

    // Reset held for two edges.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
`ifdef RAM_INIT_EN
    for (int i = 0; i < 4; i++) begin
      check("init_ready_low", int'(req_ready), 0);
      check("init_busy", int'(busy), 1);
      check("init_we", int'(ram_we), 1);
      check("init_addr", int'(ram_addr), i);
      check("init_wdata", int'(ram_wdata), 0);
      tick();
    end
    check("init_done_ready", int'(req_ready), 1);
    for (int a = 0; a < 4; a++) do_read(ADDR'(a), 0, '0);
`else
    check("rst_ready", int'(req_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ram_we", int'(ram_we), 0);
    check("rst_ram_re", int'(ram_re), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_ram_wdata", int'(ram_wdata), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_rdata", int'(rsp_rdata), 0);
`endif

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].wr) do_write(vecs[v].addr, vecs[v].data);
      else            do_read(vecs[v].addr, vecs[v].hold, vecs[v].data);
    end

    // Back-to-back writes with req_valid held high.
    wait_ready();
    acc = 0; last = -1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_wdata = 4'h1;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      bit a;
      a = req_ready;
      tick();
      if (a) begin
        if (last >= 0) check("b2b_spacing", c - last, 2);
        last = c;
        acc++;
        req_addr  = ADDR'(acc);
        req_wdata = DATA'(acc + 1);
      end
    end
    req_valid = 1'b0;
    check("b2b_accepts", acc, 4);
    for (int a = 0; a < 4; a++) do_read(ADDR'(a), 0, DATA'(a + 1));

    // Reset during the RD cycle of a read of address 3.
    do_write(2'd3, 4'h7);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd3;
    tick();
    req_valid = 1'b0;
    check("rstrd_in_rd", int'(ram_re), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrd_re_clear", int'(ram_re), 0);
    check("rstrd_no_valid", int'(rsp_valid), 0);
`ifdef RAM_INIT_EN
    check("rstrd_init_busy", int'(busy), 1);
`else
    check("rstrd_idle", int'(req_ready), 1);
`endif
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rstrd_never_valid", int'(rsp_valid), 0);
    end
`ifdef RAM_INIT_EN
    do_read(2'd3, 0, 4'h0);
`else
    do_read(2'd3, 0, 4'h7);
`endif

    // Random traffic against a reference memory.
    for (int a = 0; a < 4; a++) begin
      model[a] = DATA'(a + 8);
      do_write(ADDR'(a), model[a]);
    end
    exp_ready = 1'b1; wr_wait = 1'b0; rd_pend = 1'b0; exp_data = '0;
    done = 0; cyc = 0;
    while (done < 1000 && cyc < 30000) begin
      req_valid = 1'($urandom);
      req_write = 1'($urandom);
      req_addr  = ADDR'($urandom);
      req_wdata = DATA'($urandom);
      rsp_ready = 1'($urandom);
      #0;
      check("rand_ready", int'(req_ready), int'(exp_ready));
      if (rsp_valid && !rd_pend) check("rand_spurious_rsp", int'(rsp_valid), 0);
      n_ready = exp_ready;
      if (exp_ready && req_valid) begin
        n_ready = 1'b0;
        done++;
        if (req_write) begin
          model[req_addr] = req_wdata;
          wr_wait = 1'b1;
        end else begin
          exp_data = model[req_addr];
          rd_pend  = 1'b1;
        end
      end else if (wr_wait) begin
        wr_wait = 1'b0;
        n_ready = 1'b1;
      end else if (rd_pend && rsp_valid && rsp_ready) begin
        check("rand_rdata", int'(rsp_rdata), int'(exp_data));
        rd_pend = 1'b0;
        n_ready = 1'b1;
      end
      tick();
      exp_ready = n_ready;
      cyc++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("rand_requests", done, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
